// File: rtl/cls_fault_manager_if.sv
// Fault-manager bus: compare-unit fault inputs, software clear, and the core reset/diagnostic outputs.
// The slave side is the fault manager; the master side is the compare unit and software.
interface cls_fault_manager_if;
    logic        fault_i;
    logic [2:0]  fault_code_i;
    logic [31:0] fault_addr_i;
    logic        clr_i;
    logic        core_rst_o;
    logic        halted_o;
    logic [3:0]  retry_cnt_o;
    logic [15:0] fault_cnt_o;
    logic [2:0]  last_code_o;
    logic [31:0] last_addr_o;

    modport master (
        output fault_i, fault_code_i, fault_addr_i, clr_i,
        input  core_rst_o, halted_o, retry_cnt_o, fault_cnt_o, last_code_o, last_addr_o
    );

    modport slave (
        input  fault_i, fault_code_i, fault_addr_i, clr_i,
        output core_rst_o, halted_o, retry_cnt_o, fault_cnt_o, last_code_o, last_addr_o
    );
endinterface

// File: rtl/cls_fault_manager.sv
// Lockstep fault manager: bounded core-reset retries, escalation to halt, syndrome capture and fault counting.
// Fault-to-core-reset latency 1 cycle; no backpressure, fault_i is simply ignored outside RUN.
module cls_fault_manager #(
    parameter int RST_CYCLES  = 2,
    parameter int MAX_RETRIES = 3,
    parameter int WINDOW      = 1024
) (
    input  logic              clk,
    input  logic              rst,
    cls_fault_manager_if.slave bus
);
    localparam int CW = $clog2(WINDOW + 1);
    localparam logic [CW-1:0] WIN_C      = CW'(WINDOW);
    localparam logic [7:0]    RST_LAST_C = 8'(RST_CYCLES - 1);
    localparam logic [3:0]    MAX_C      = 4'(MAX_RETRIES);

    typedef enum logic [1:0] {S_RESET, S_GUARD, S_RUN, S_HALT} state_t;

    state_t         state;
    logic [7:0]     rst_cnt;
    logic [CW-1:0]  clean_cnt;
    logic           core_rst_q;
    logic           halted_q;
    logic [3:0]     retry_q;
    logic [15:0]    fault_cnt_q;
    logic [2:0]     last_code_q;
    logic [31:0]    last_addr_q;

    logic [3:0]     retry_base;
    logic [3:0]     retry_eff;
    logic [CW-1:0]  clean_base;
    logic [CW-1:0]  clean_inc;
    logic           win_hit;

    // Ordering inside a RUN cycle: software clear, then window expiry, then the fault.
    always_comb begin
        retry_base = bus.clr_i ? 4'd0 : retry_q;
        clean_base = bus.clr_i ? '0 : clean_cnt;
        clean_inc  = clean_base + 1'b1;
        win_hit    = (clean_inc == WIN_C);
        retry_eff  = win_hit ? 4'd0 : retry_base;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_RESET;
            rst_cnt     <= 8'd0;
            clean_cnt   <= '0;
            core_rst_q  <= 1'b1;
            halted_q    <= 1'b0;
            retry_q     <= 4'd0;
            fault_cnt_q <= 16'd0;
            last_code_q <= 3'd0;
            last_addr_q <= 32'd0;
        end else begin
            case (state)
                S_RESET: begin
                    if (bus.clr_i) begin
                        retry_q   <= 4'd0;
                        clean_cnt <= '0;
                    end
                    if (rst_cnt == RST_LAST_C) begin
                        state      <= S_GUARD;
                        core_rst_q <= 1'b0;
                    end else begin
                        rst_cnt <= rst_cnt + 8'd1;
                    end
                end
                S_GUARD: begin
                    if (bus.clr_i) retry_q <= 4'd0;
                    clean_cnt <= '0;
                    state     <= S_RUN;
                end
                S_RUN: begin
                    if (bus.fault_i) begin
                        last_code_q <= bus.fault_code_i;
                        last_addr_q <= bus.fault_addr_i;
                        if (fault_cnt_q != 16'hFFFF) fault_cnt_q <= fault_cnt_q + 16'd1;
                        clean_cnt  <= '0;
                        core_rst_q <= 1'b1;
                        if (retry_eff == MAX_C) begin
                            state    <= S_HALT;
                            halted_q <= 1'b1;
                            retry_q  <= retry_eff;
                        end else begin
                            state   <= S_RESET;
                            rst_cnt <= 8'd0;
                            retry_q <= retry_eff + 4'd1;
                        end
                    end else if (win_hit) begin
                        retry_q   <= 4'd0;
                        clean_cnt <= '0;
                    end else begin
                        retry_q   <= retry_base;
                        clean_cnt <= clean_inc;
                    end
                end
                S_HALT: begin
                    if (bus.clr_i) begin
                        halted_q <= 1'b0;
                        retry_q  <= 4'd0;
                        state    <= S_RESET;
                        rst_cnt  <= 8'd0;
                    end
                end
                default: begin
                    state      <= S_RESET;
                    rst_cnt    <= 8'd0;
                    core_rst_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.core_rst_o  = core_rst_q;
    assign bus.halted_o    = halted_q;
    assign bus.retry_cnt_o = retry_q;
    assign bus.fault_cnt_o = fault_cnt_q;
    assign bus.last_code_o = last_code_q;
    assign bus.last_addr_o = last_addr_q;
endmodule

// File: tb/tb_cls_fault_manager.sv
// Randomized bench for cls_fault_manager against a timeline-based reference model.
// The model tracks when the last recovery began and derives reset/guard/run phases from elapsed cycles.
module tb_cls_fault_manager;
    localparam int RC  = 2;
    localparam int MR  = 3;
    localparam int WIN = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cls_fault_manager_if bus();

    cls_fault_manager #(
        .RST_CYCLES (RC),
        .MAX_RETRIES(MR),
        .WINDOW     (WIN)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: edge count, edge at which the current recovery started, and software-visible state.
    int          cyc = 0;
    int          t0 = 0;
    bit          m_halt = 1'b0;
    int          m_retry = 0;
    int          m_fcnt = 0;
    int          m_clean = 0;
    logic [2:0]  m_code = 3'd0;
    logic [31:0] m_addr = 32'd0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    // Applies the inputs sampled at one rising edge to the model.
    task automatic model_edge();
        int d;
        d = cyc - t0;
        cyc++;
        if (rst) begin
            t0 = cyc; m_halt = 1'b0; m_retry = 0; m_fcnt = 0; m_clean = 0;
            m_code = 3'd0; m_addr = 32'd0;
        end else if (m_halt) begin
            if (bus.clr_i) begin
                m_halt = 1'b0; m_retry = 0; t0 = cyc;
            end
        end else if (d <= RC) begin
            if (bus.clr_i) m_retry = 0;
            m_clean = 0;
        end else begin
            if (bus.clr_i) begin
                m_retry = 0; m_clean = 0;
            end
            if (bus.fault_i) begin
                m_code = bus.fault_code_i;
                m_addr = bus.fault_addr_i;
                if (m_fcnt < 65535) m_fcnt++;
                if (m_clean + 1 == WIN) m_retry = 0;
                m_clean = 0;
                if (m_retry == MR) m_halt = 1'b1;
                else begin
                    m_retry++; t0 = cyc;
                end
            end else begin
                m_clean++;
                if (m_clean == WIN) begin
                    m_retry = 0; m_clean = 0;
                end
            end
        end
    endtask

    task automatic check_all();
        int  d;
        bit  exp_rst;
        d = cyc - t0;
        exp_rst = m_halt || (d < RC);
        check("core_rst", 32'(bus.core_rst_o), 32'(exp_rst));
        check("halted", 32'(bus.halted_o), 32'(m_halt));
        check("retry_cnt", 32'(bus.retry_cnt_o), 32'(m_retry));
        check("fault_cnt", 32'(bus.fault_cnt_o), 32'(m_fcnt));
        check("last_code", 32'(bus.last_code_o), 32'(m_code));
        check("last_addr", bus.last_addr_o, m_addr);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic segment(input int n, input int fault_pct, input int clr_pct, input int rst_pct);
        for (int i = 0; i < n; i++) begin
            rst              = ($urandom_range(999, 0) < 10 * rst_pct);
            bus.fault_i      = ($urandom_range(99, 0) < fault_pct);
            bus.fault_code_i = 3'($urandom_range(7, 0));
            bus.fault_addr_i = $urandom;
            bus.clr_i        = ($urandom_range(99, 0) < clr_pct);
            tick();
        end
    endtask

    initial begin
        rst              = 1'b1;
        bus.fault_i      = 1'b0;
        bus.fault_code_i = 3'd0;
        bus.fault_addr_i = 32'd0;
        bus.clr_i        = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        repeat (6) tick();
        // Directed single fault, then held fault through recovery and escalation.
        bus.fault_i = 1'b1; bus.fault_code_i = 3'd2; bus.fault_addr_i = 32'h0000_1F40;
        tick();
        repeat (20) tick();
        bus.fault_i = 1'b0;
        repeat (3) tick();
        bus.clr_i = 1'b1;
        tick();
        bus.clr_i = 1'b0;
        repeat (6) tick();
        segment(400, 20, 3, 0);
        segment(600, 2, 1, 0);
        segment(300, 100, 4, 1);
        segment(1000, 8, 2, 1);
        segment(500, 1, 0, 0);
        segment(800, 40, 5, 2);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/cls_fault_manager.md
# cls_fault_manager

Fault manager for the triple-core lockstep cluster. It sits directly downstream of the lockstep compare unit. It consumes the comparator's fault flag and a fault syndrome, then drives a registered reset pulse to all three cores. It bounds retries and escalates to a permanent halt when faults recur. It also captures the last fault syndrome and counts faults for software diagnosis.

## Interface
Parameters:
- RST_CYCLES, 2: number of cycles core_rst_o is held high per recovery; legal range 1..255.
- MAX_RETRIES, 3: number of recoveries allowed inside one clean window before halting; legal range 1..15.
- WINDOW, 1024: number of consecutive fault-free RUN cycles that clears the retry count; legal range 2..2^20.

Ports (clock and reset first):
- clk, in, 1: single clock; all logic is on the rising edge.
- rst, in, 1: synchronous, active-high reset.
- fault_i, in, 1: mismatch flag from the compare unit; combinational on their side; sampled only in RUN.
- fault_code_i, in, 3: syndrome. 1 = data req, 2 = data addr, 3 = data we, 4 = data wdata, 5 = instr req, 6 = instr addr; 0 and 7 are reserved.
- fault_addr_i, in, 32: master core address associated with the fault.
- clr_i, in, 1: software clear, single-cycle pulse.
- core_rst_o, out, 1: active-high reset to all three cores; registered.
- halted_o, out, 1: permanent-failure flag.
- retry_cnt_o, out, 4: recoveries taken in the current window.
- fault_cnt_o, out, 16: total faults since rst; saturates at 16'hFFFF.
- last_code_o, out, 3: syndrome of the most recent accepted fault.
- last_addr_o, out, 32: address of the most recent accepted fault.

## Operation
- FSM states: RESET, GUARD, RUN, HALT.
- While rst is high:
  - state = RESET and the reset-cycle counter = 0.
  - core_rst_o = 1, halted_o = 0.
  - retry_cnt_o = 0, fault_cnt_o = 0, last_code_o = 0, last_addr_o = 0.
  - The clean counter = 0.
- RESET: core_rst_o = 1 for RST_CYCLES cycles, then go to GUARD. fault_i is ignored.
- GUARD: core_rst_o = 0 for exactly 1 cycle. fault_i is ignored, because the comparator is settling on fresh core outputs. Then go to RUN with the clean counter = 0.
- RUN: core_rst_o = 0. A fault is accepted when fault_i = 1 at a clock edge:
  - last_code_o and last_addr_o capture the inputs.
  - fault_cnt_o increments, saturating.
  - If retry_cnt_o == MAX_RETRIES, go to HALT.
  - Otherwise retry_cnt_o increments and the FSM goes to RESET.
- RUN, fault-free cycle: the clean counter increments. When it reaches WINDOW, retry_cnt_o = 0 and the clean counter = 0.
- HALT: core_rst_o = 1 and halted_o = 1 indefinitely; fault_i is ignored. clr_i sets halted_o = 0 and retry_cnt_o = 0, then goes to RESET.
- clr_i in RESET, GUARD or RUN: clears retry_cnt_o and the clean counter only. State is unchanged. fault_cnt_o and last_* are never cleared by clr_i.
- clr_i and an accepted fault in the same RUN cycle: the clear applies first, then the fault is counted. Result: retry_cnt_o = 1, next state RESET.
- A fault on the same cycle the clean counter reaches WINDOW: the fault wins. The window is cleared, then the fault is counted, so retry_cnt_o = 1.
- rst asserted mid-recovery or in HALT: all state and outputs return to their reset values on the next edge.

## Timing
- Fault sampled in RUN at edge T:
  - core_rst_o = 1 from T+1 through T+RST_CYCLES.
  - GUARD at T+RST_CYCLES+1, with core_rst_o = 0.
  - RUN resumes at T+RST_CYCLES+2; fault_i is sampled from that edge on.
- last_code_o, last_addr_o, fault_cnt_o and retry_cnt_o update at T+1.
- Escalating fault at edge T: halted_o = 1 and core_rst_o = 1 from T+1.
- After rst deasserts at edge R:
  - core_rst_o stays 1 through R+RST_CYCLES.
  - GUARD at R+RST_CYCLES+1.
  - RUN at R+RST_CYCLES+2.
- All outputs are registered; there is no combinational path from any input to any output.
- Worst-case fault-to-core-reset latency is 1 cycle.

## Test plan
All scenarios use RST_CYCLES = 2, MAX_RETRIES = 3, WINDOW = 16.
1. Release rst, no faults: core_rst_o = 1 for 2 cycles after release, 0 in GUARD; RUN from the 4th cycle. All counters stay 0.
2. Single fault, code 2, address 0x0000_1F40, in RUN: next cycle last_code_o = 2, last_addr_o = 0x0000_1F40, fault_cnt_o = 1, retry_cnt_o = 1. core_rst_o is high for exactly 2 cycles, then low for GUARD. fault_i held high through RESET and GUARD is not counted.
3. Four faults, each injected on the first RUN cycle after recovery: retry_cnt_o steps 1, 2, 3. The 4th fault sets halted_o = 1, keeps core_rst_o = 1, and gives fault_cnt_o = 4. A later clr_i pulse clears halted_o and retry_cnt_o, and the FSM runs a 2-cycle reset, then GUARD, then RUN.
4. Window expiry: a fault, then 16 clean RUN cycles, makes retry_cnt_o return 0. Three more faults then leave halted_o = 0 with retry_cnt_o = 3.
5. clr_i coincident with a fault while retry_cnt_o = 2: the result is retry_cnt_o = 1, the FSM enters RESET, and fault_cnt_o increments.
6. rst asserted during HALT and again during RESET: on the next edge every output takes its reset value, and the release sequence matches scenario 1.
